dff_pipe_async_clear: RTL

//  Parametrised multi-stage register pipeline with per-stage valid bit, stall, flush and async clear.

---
 rtl/dff_pipe_async_clear_pkg.sv | 27 ++
 rtl/dff_pipe_async_clear_if.sv | 27 ++
 rtl/dff_pipe_async_clear_dff_async_en.sv | 23 ++
 rtl/dff_pipe_async_clear.sv | 70 +++++++
 4 files changed

// File: rtl/dff_pipe_async_clear_pkg.sv
// Shared constants and occupancy helpers for the MIPS stage-register pipelines.
// Purely declarative: no latency, no flow control of its own.
package dff_pipe_async_clear_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;
    localparam logic [DEF_WIDTH-1:0] PIPE_RESET_VAL = '0;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'd0,
        OCC_INC  = 2'd1,
        OCC_DEC  = 2'd2
    } occ_op_t;

    // Net effect of one shift edge on the valid-stage count.
    function automatic occ_op_t occ_decode(input logic enters, input logic leaves);
        occ_op_t op;
        op = OCC_HOLD;
        if (enters && !leaves) begin
            op = OCC_INC;
        end else if (!enters && leaves) begin
            op = OCC_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/dff_pipe_async_clear_if.sv
// Data/control bundle for one pipeline-register chain.
// Carries stall/flush towards the pipe; q/out_valid/occupancy back out.
interface dff_pipe_async_clear_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [OW-1:0]    occupancy;

    modport master (
        output d, in_valid, stall, flush,
        input  q, out_valid, occupancy
    );

    modport slave (
        input  d, in_valid, stall, flush,
        output q, out_valid, occupancy
    );

endinterface

// File: rtl/dff_pipe_async_clear_dff_async_en.sv
// One stage register {valid,data}: 1-cycle latency, async active-low clear.
// Holds when en is low; load forces RESET_VAL on an enabled edge.
module dff_async_en #(
    parameter int           W         = 9,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clock,
    input  logic         clearb,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= load ? RESET_VAL : d;
        end
    end

endmodule

// File: rtl/dff_pipe_async_clear.sv
// DEPTH-stage valid-tagged register pipe, latency DEPTH shift edges.
// stall freezes every stage (input dropped); flush empties the pipe on the next edge.
module dff_pipe_async_clear
    import dff_pipe_async_clear_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                 clock,
    input  logic                 clearb,
    dff_pipe_async_clear_if.slave bus
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [WIDTH:0] STAGE_RESET = {1'b0, RESET_VAL};

    // Each stage word is {valid, data}; bubbles always carry RESET_VAL.
    logic [WIDTH:0] stage_d [DEPTH];
    logic [WIDTH:0] stage_q [DEPTH];
    logic           en;
    logic           load;
    logic           out_valid;
    logic [OW-1:0]  occ;

    assign en   = ~bus.stall | bus.flush;
    assign load = bus.flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[0] = bus.in_valid ? {1'b1, bus.d} : STAGE_RESET;
        end else begin : g_body
            assign stage_d[i] = stage_q[i-1];
        end

        dff_async_en #(
            .W         (WIDTH + 1),
            .RESET_VAL (STAGE_RESET)
        ) u_reg (
            .clock  (clock),
            .clearb (clearb),
            .en     (en),
            .load   (load),
            .d      (stage_d[i]),
            .q      (stage_q[i])
        );
    end

    assign out_valid = stage_q[DEPTH-1][WIDTH];

    // Tracks popcount of the valid bits without an adder tree across stages.
    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            occ <= '0;
        end else if (bus.flush) begin
            occ <= '0;
        end else if (!bus.stall) begin
            case (occ_decode(bus.in_valid, out_valid))
                OCC_INC: occ <= occ + OW'(1);
                OCC_DEC: occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign bus.q         = stage_q[DEPTH-1][WIDTH-1:0];
    assign bus.out_valid = out_valid;
    assign bus.occupancy = occ;

endmodule
